// File: rtl/match_trigger_if.sv
// Bus bundle between the sniffer side and the match trigger stage.
interface match_trigger_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 32
);
  logic                 match;
  logic [WIDTH-1:0]     data;
  logic                 arm;
  logic                 disarm;
  logic [CNT_WIDTH-1:0] threshold;
  logic [CNT_WIDTH-1:0] holdoff;
  logic                 ack;

  logic                 trig;
  logic                 irq;
  logic                 overflow;
  logic [WIDTH-1:0]     cap_data;
  logic [TS_WIDTH-1:0]  cap_ts;
  logic [CNT_WIDTH-1:0] match_count;
  logic [1:0]           state;

  // Software side drives the controls; the trigger stage drives results.
  modport master (
    output match, data, arm, disarm, threshold, holdoff, ack,
    input  trig, irq, overflow, cap_data, cap_ts, match_count, state
  );

  modport slave (
    input  match, data, arm, disarm, threshold, holdoff, ack,
    output trig, irq, overflow, cap_data, cap_ts, match_count, state
  );
endinterface

// File: rtl/match_trigger.sv
// Counts comparator match pulses while armed, fires a trigger at a threshold,
// captures the bus word and timestamp, and raises an acknowledged interrupt.
module match_trigger #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 32
) (
  input logic            clk,
  input logic            reset,
  match_trigger_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_HOLDOFF = 2'b10
  } state_t;

  state_t               st;
  logic [TS_WIDTH-1:0]  ts;
  logic [WIDTH-1:0]     data_d;
  logic [CNT_WIDTH-1:0] thr_q;
  logic [CNT_WIDTH-1:0] hold_q;
  logic [CNT_WIDTH-1:0] hcnt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 trig_q;
  logic                 irq_q;
  logic                 ovf_q;
  logic [WIDTH-1:0]     cap_data_q;
  logic [TS_WIDTH-1:0]  cap_ts_q;

  logic [CNT_WIDTH:0]   cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_sat;
  logic                 hit;

  // Threshold compare is one bit wider so a saturated count still reaches it.
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign cnt_sat = (&cnt) ? cnt : cnt + 1'b1;
  assign hit     = bus.match && (cnt_inc >= {1'b0, thr_q});

  // irq is a level held until ack; ack is a single-cycle pulse that clears it
  // unless a trigger lands in the same cycle, in which case irq stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IDLE;
      ts         <= '0;
      data_d     <= '0;
      thr_q      <= '0;
      hold_q     <= '0;
      hcnt       <= '0;
      cnt        <= '0;
      trig_q     <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cap_data_q <= '0;
      cap_ts_q   <= '0;
    end else begin
      ts     <= ts + 1'b1;
      data_d <= bus.data;
      trig_q <= 1'b0;
      if (bus.ack) begin
        irq_q <= 1'b0;
        ovf_q <= 1'b0;
      end

      if (bus.disarm) begin
        st <= S_IDLE;
      end else if (bus.arm) begin
        st     <= S_ARMED;
        cnt    <= '0;
        thr_q  <= (bus.threshold == '0) ? CNT_WIDTH'(1) : bus.threshold;
        hold_q <= bus.holdoff;
      end else begin
        case (st)
          S_ARMED: begin
            if (hit) begin
              trig_q <= 1'b1;
              irq_q  <= 1'b1;
              cnt    <= '0;
              // A pending, unacknowledged irq keeps the first capture.
              if (irq_q && !bus.ack) begin
                ovf_q <= 1'b1;
              end else begin
                cap_data_q <= data_d;
                cap_ts_q   <= ts;
              end
              if (hold_q == '0) begin
                st <= S_ARMED;
              end else begin
                st   <= S_HOLDOFF;
                hcnt <= hold_q;
              end
            end else if (bus.match) begin
              cnt <= cnt_sat;
            end
          end
          S_HOLDOFF: begin
            if (hcnt == CNT_WIDTH'(1)) st <= S_ARMED;
            else                       hcnt <= hcnt - 1'b1;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.trig        = trig_q;
  assign bus.irq         = irq_q;
  assign bus.overflow    = ovf_q;
  assign bus.cap_data    = cap_data_q;
  assign bus.cap_ts      = cap_ts_q;
  assign bus.match_count = cnt;
  assign bus.state       = st;

endmodule
